// File: rtl/controlador_embalagem.sv
// rtl/controlador_embalagem.sv - egg packing controller: fills boxes, ejects them, flags a full batch
//
// Purpose:
//   Counts eggs into a box and ejects the box after DUZIA eggs. It raises the
//   batch-full alarm after MAX_DUZIAS boxes. The operator drives start/stop.
//
// Ports:
//   clk            in   single clock, all state on the rising edge
//   reset_n        in   asynchronous active-low reset
//   start          in   operator start level (rising edge acts)
//   stop           in   operator stop level (sampled every cycle)
//   sensor_ovo     in   egg sensor level (rising edge acts)
//   caixa_presente in   box sitting in the fill position
//   motor_esteira  out  conveyor motor enable (registered)
//   ejetar_caixa   out  box ejector drive (registered)
//   ovos_na_caixa  out  eggs in the current box, 0..DUZIA-1
//   duzias_total   out  boxes completed in the batch, 0..MAX_DUZIAS
//   alarme_cheio   out  batch complete (registered)
//   estado         out  current state code
module controlador_embalagem #(
  parameter int DUZIA      = 12,
  parameter int MAX_DUZIAS = 10,
  parameter int T_EJECAO   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       stop,
  input  logic       sensor_ovo,
  input  logic       caixa_presente,
  output logic       motor_esteira,
  output logic       ejetar_caixa,
  output logic [3:0] ovos_na_caixa,
  output logic [6:0] duzias_total,
  output logic       alarme_cheio,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    ESPERA_CAIXA = 3'd1,
    ENCHENDO     = 3'd2,
    EJETANDO     = 3'd3,
    CHEIO        = 3'd4
  } estado_t;

  localparam logic [3:0] OVOS_ULTIMO = 4'(DUZIA - 1);
  localparam logic [6:0] DUZIAS_MAX  = 7'(MAX_DUZIAS);
  localparam logic [3:0] TIMER_FIM   = 4'(T_EJECAO - 1);

  estado_t    estado_q, estado_d;
  logic [3:0] ovos_q, ovos_d;
  logic [6:0] duzias_q, duzias_d;
  logic [3:0] timer_q, timer_d;
  logic       start_q, sensor_q;
  logic       motor_q, ejetar_q, alarme_q;

  // The previous-value registers reset to 0. An input that is already high
  // when reset is released therefore counts as one edge.
  logic start_edge, ovo_edge, ovo_valido;
  assign start_edge = start & ~start_q;
  assign ovo_edge   = sensor_ovo & ~sensor_q;
  assign ovo_valido = ovo_edge & caixa_presente;

  always_comb begin
    estado_d = estado_q;
    ovos_d   = ovos_q;
    duzias_d = duzias_q;
    timer_d  = timer_q;
    case (estado_q)
      IDLE: begin
        if (!stop && start_edge) estado_d = ESPERA_CAIXA;
      end
      ESPERA_CAIXA: begin
        if (stop)                estado_d = IDLE;
        else if (caixa_presente) estado_d = ENCHENDO;
      end
      ENCHENDO: begin
        if (ovo_valido && ovos_q == OVOS_ULTIMO) begin
          // The completing egg wins over a simultaneous stop.
          ovos_d   = '0;
          duzias_d = duzias_q + 7'd1;
          timer_d  = '0;
          estado_d = EJETANDO;
        end else begin
          // A non-completing egg still counts even while stopping.
          if (ovo_valido) ovos_d = ovos_q + 4'd1;
          if (stop)       estado_d = IDLE;
        end
      end
      EJETANDO: begin
        // The timer counts 0..T_EJECAO-1, so the state lasts T_EJECAO cycles.
        if (timer_q == TIMER_FIM) begin
          if (duzias_q == DUZIAS_MAX) estado_d = CHEIO;
          else if (stop)              estado_d = IDLE;
          else                        estado_d = ESPERA_CAIXA;
        end else begin
          timer_d = timer_q + 4'd1;
        end
      end
      CHEIO: begin
        if (start_edge) begin
          duzias_d = '0;
          ovos_d   = '0;
          estado_d = ESPERA_CAIXA;
        end
      end
      default: estado_d = IDLE;
    endcase
  end

  // Output flops decode the next state. Each output therefore changes on
  // the same edge that enters its state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= IDLE;
      ovos_q   <= '0;
      duzias_q <= '0;
      timer_q  <= '0;
      start_q  <= 1'b0;
      sensor_q <= 1'b0;
      motor_q  <= 1'b0;
      ejetar_q <= 1'b0;
      alarme_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      ovos_q   <= ovos_d;
      duzias_q <= duzias_d;
      timer_q  <= timer_d;
      start_q  <= start;
      sensor_q <= sensor_ovo;
      motor_q  <= (estado_d == ENCHENDO) && caixa_presente;
      ejetar_q <= (estado_d == EJETANDO);
      alarme_q <= (estado_d == CHEIO);
    end
  end

  assign motor_esteira = motor_q;
  assign ejetar_caixa  = ejetar_q;
  assign alarme_cheio  = alarme_q;
  assign ovos_na_caixa = ovos_q;
  assign duzias_total  = duzias_q;
  assign estado        = estado_q;

endmodule

// File: tb/tb_controlador_embalagem.sv
// tb/tb_controlador_embalagem.sv - scoreboard bench for controlador_embalagem
module tb_controlador_embalagem;

  logic       clk;
  logic       reset_n;
  logic       start, stop, sensor_ovo, caixa_presente;
  logic       motor_esteira, ejetar_caixa, alarme_cheio;
  logic [3:0] ovos_na_caixa;
  logic [6:0] duzias_total;
  logic [2:0] estado;

  controlador_embalagem #(.DUZIA(12), .MAX_DUZIAS(10), .T_EJECAO(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .stop           (stop),
    .sensor_ovo     (sensor_ovo),
    .caixa_presente (caixa_presente),
    .motor_esteira  (motor_esteira),
    .ejetar_caixa   (ejetar_caixa),
    .ovos_na_caixa  (ovos_na_caixa),
    .duzias_total   (duzias_total),
    .alarme_cheio   (alarme_cheio),
    .estado         (estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] ov;
    logic [6:0] dz;
    logic       ej;
    logic       al;
  } snap_t;

  snap_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    mon_armed   = 0;
  bit    mon_started = 0;
  snap_t last_snap;
  int    dwell = 0;

  task automatic push_exp(input int st, input int ov, input int dz, input int ej, input int al);
    snap_t s;
    s.st = 3'(st); s.ov = 4'(ov); s.dz = 7'(dz); s.ej = 1'(ej); s.al = 1'(al);
    exp_q.push_back(s);
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic egg;
    sensor_ovo = 1'b1;
    tick();
    sensor_ovo = 1'b0;
    tick();
  endtask

  // n egg pulses starting from ov0 eggs; the 12th egg closes the box
  task automatic eggs(input int n, input int ov0, input int dz);
    for (int i = 1; i <= n; i++) begin
      if (ov0 + i == 12) push_exp(3, 0, dz + 1, 1, 0);
      else               push_exp(2, ov0 + i, dz, 0, 0);
      egg();
    end
  endtask

  // remaining ejection cycles, then ESPERA_CAIXA and back to ENCHENDO
  task automatic after_eject(input int dz);
    push_exp(1, 0, dz, 0, 0);
    push_exp(2, 0, dz, 0, 0);
    repeat (4) tick();
  endtask

  // Monitor: each time the visible output tuple changes, pop and compare.
  always @(negedge clk) begin
    snap_t cur;
    snap_t e;
    cur = {estado, ovos_na_caixa, duzias_total, ejetar_caixa, alarme_cheio};
    if (mon_armed) begin
      if (!mon_started || cur != last_snap) begin
        if (mon_started && last_snap.st == 3'd3 && reset_n) begin
          n_checks++;
          if (dwell != 4) begin
            n_fail++;
            $display("FAIL eject_len: got %0d cycles, expected 4", dwell);
          end
        end
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change: got st=%0d ov=%0d dz=%0d ej=%0d al=%0d, expected none",
                   cur.st, cur.ov, cur.dz, cur.ej, cur.al);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            n_fail++;
            $display("FAIL snapshot: got st=%0d ov=%0d dz=%0d ej=%0d al=%0d, expected st=%0d ov=%0d dz=%0d ej=%0d al=%0d",
                     cur.st, cur.ov, cur.dz, cur.ej, cur.al, e.st, e.ov, e.dz, e.ej, e.al);
          end
        end
        last_snap   = cur;
        dwell       = 1;
        mon_started = 1;
      end else begin
        dwell++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    start = 1'b0; stop = 1'b0; sensor_ovo = 1'b0; caixa_presente = 1'b0;
    push_exp(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    reset_n   = 1'b1;
    mon_armed = 1;
    tick();

    // First box: start, box present, 12 eggs
    caixa_presente = 1'b1;
    push_exp(1, 0, 0, 0, 0);
    push_exp(2, 0, 0, 0, 0);
    start = 1'b1; tick(); start = 1'b0; tick();
    chk("motor_filling", motor_esteira, 1);
    eggs(12, 0, 0);
    after_eject(1);

    // Boxes 2..10 end in CHEIO
    for (int b = 2; b <= 10; b++) begin
      eggs(12, 0, b - 1);
      if (b < 10) after_eject(b);
      else begin
        push_exp(4, 0, 10, 0, 1);
        repeat (4) tick();
      end
    end
    chk("cheio_alarm", alarme_cheio, 1);
    chk("cheio_duzias", duzias_total, 10);
    chk("cheio_motor", motor_esteira, 0);

    // CHEIO ignores stop; a start edge clears the batch
    stop = 1'b1; tick(); stop = 1'b0; tick();
    push_exp(1, 0, 0, 0, 0);
    push_exp(2, 0, 0, 0, 0);
    start = 1'b1; tick(); start = 1'b0; tick();

    // A sensor held high counts once
    push_exp(2, 1, 0, 0, 0);
    sensor_ovo = 1'b1;
    repeat (20) tick();
    sensor_ovo = 1'b0;
    tick();

    // No box: motor off, eggs ignored
    caixa_presente = 1'b0; tick();
    chk("motor_no_box", motor_esteira, 0);
    egg(); egg();
    chk("ovos_no_box", ovos_na_caixa, 1);
    caixa_presente = 1'b1; tick();
    chk("motor_box_back", motor_esteira, 1);

    // Up to 5 eggs, stop keeps the count, resume and complete with 7 more
    eggs(4, 1, 0);
    push_exp(0, 5, 0, 0, 0);
    stop = 1'b1; tick(); stop = 1'b0;
    push_exp(1, 5, 0, 0, 0);
    push_exp(2, 5, 0, 0, 0);
    start = 1'b1; tick(); start = 1'b0; tick();
    chk("ovos_kept", ovos_na_caixa, 5);
    eggs(7, 5, 0);
    after_eject(1);

    // 12th egg coincides with stop: eject, then IDLE
    eggs(11, 0, 1);
    push_exp(3, 0, 2, 1, 0);
    push_exp(0, 0, 2, 0, 0);
    sensor_ovo = 1'b1; stop = 1'b1; tick();
    sensor_ovo = 1'b0; tick();
    chk("eject_motor", motor_esteira, 0);
    chk("eject_drive", ejetar_caixa, 1);
    repeat (3) tick();
    stop = 1'b0;
    chk("stop_eject_dz", duzias_total, 2);

    // In IDLE stop beats start
    stop = 1'b1; start = 1'b1; tick();
    start = 1'b0; stop = 1'b0; tick();
    chk("stop_priority", estado, 0);

    // ESPERA_CAIXA waits for a box, stop returns to IDLE
    caixa_presente = 1'b0;
    push_exp(1, 0, 2, 0, 0);
    start = 1'b1; tick(); start = 1'b0; tick();
    push_exp(0, 0, 2, 0, 0);
    stop = 1'b1; tick(); stop = 1'b0; tick();

    // Asynchronous reset in the middle of an ejection
    caixa_presente = 1'b1;
    push_exp(1, 0, 2, 0, 0);
    push_exp(2, 0, 2, 0, 0);
    start = 1'b1; tick(); start = 1'b0; tick();
    eggs(12, 0, 2);
    push_exp(0, 0, 0, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_motor", motor_esteira, 0);
    chk("rst_eject", ejetar_caixa, 0);
    chk("rst_alarm", alarme_cheio, 0);
    chk("rst_ovos", ovos_na_caixa, 0);
    chk("rst_duzias", duzias_total, 0);
    chk("rst_estado", estado, 0);
    #20;
    reset_n = 1'b1;
    repeat (5) tick();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/controlador_embalagem.md
CONTROLADOR_EMBALAGEM -- requirements
Module: controlador_embalagem

Interface
REQ-001 SHALL have parameter DUZIA, default 12: eggs per box.
REQ-002 SHALL have parameter MAX_DUZIAS, default 10: boxes per batch.
REQ-003 SHALL have parameter T_EJECAO, default 4: ejector-active cycles per box (legal range 1..15).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  operator start level, rising-edge detected.
REQ-007 SHALL have port stop  input  1  operator stop level, sampled every cycle.
REQ-008 SHALL have port sensor_ovo  input  1  egg sensor level, rising-edge detected.
REQ-009 SHALL have port caixa_presente  input  1  box in fill position, level.
REQ-010 SHALL have port motor_esteira  output  1  conveyor motor enable, registered.
REQ-011 SHALL have port ejetar_caixa  output  1  box ejector drive, registered.
REQ-012 SHALL have port ovos_na_caixa  output  4  eggs in current box, 0..DUZIA-1.
REQ-013 SHALL have port duzias_total  output  7  boxes completed in batch, 0..MAX_DUZIAS.
REQ-014 SHALL have port alarme_cheio  output  1  batch complete, registered.
REQ-015 SHALL have port estado  output  3  current FSM state code.

Function
REQ-016 SHALL implement FSM states IDLE=0, ESPERA_CAIXA=1, ENCHENDO=2, EJETANDO=3, CHEIO=4; other codes SHALL return to IDLE next cycle.
REQ-017 SHALL detect edges as signal=1 and registered previous value=0; previous-value registers reset to 0, so an input already high at reset release counts as one edge.
REQ-018 IDLE: motor 0, ejector 0; start edge with stop=0 -> ESPERA_CAIXA; stop has priority over start.
REQ-019 ESPERA_CAIXA: motor 0; caixa_presente=1 -> ENCHENDO; stop=1 -> IDLE.
REQ-020 ENCHENDO: motor_esteira = caixa_presente, registered, so one cycle late.
REQ-021 ENCHENDO: sensor_ovo edge with caixa_presente=1 SHALL increment ovos_na_caixa; edge with caixa_presente=0 SHALL be ignored.
REQ-022 On the DUZIA-th counted egg: ovos_na_caixa <= 0, duzias_total += 1, -> EJETANDO in the same edge; this overrides a simultaneous stop.
REQ-023 ENCHENDO with stop=1 and no completing egg -> IDLE; ovos_na_caixa is kept, and a non-completing egg edge in that cycle is still counted.
REQ-024 EJETANDO: ejetar_caixa=1 and motor 0 for exactly T_EJECAO cycles; egg edges ignored; start and stop ignored until exit.
REQ-025 EJETANDO exit: duzias_total==MAX_DUZIAS -> CHEIO; else stop=1 -> IDLE; else -> ESPERA_CAIXA.
REQ-026 CHEIO: alarme_cheio=1, motor 0; start edge -> duzias_total <= 0, ovos_na_caixa <= 0, -> ESPERA_CAIXA; stop ignored.
REQ-027 ejetar_caixa and alarme_cheio SHALL be registered decodes of the next state; both rise in the cycle the FSM enters the state.
REQ-028 Counters SHALL never exceed DUZIA-1 and MAX_DUZIAS respectively; no wrap occurs without passing through CHEIO.
REQ-029 The internal ejection timer SHALL be 4 bits and cleared on every EJETANDO entry.

Reset
REQ-030 Assertion of reset_n=0 SHALL immediately force IDLE, motor_esteira=0, ejetar_caixa=0, alarme_cheio=0, ovos_na_caixa=0, duzias_total=0, timer=0, edge registers=0, including mid-ejection.
REQ-031 Deassertion SHALL be synchronous to clk for all flops; the first active edge after release evaluates IDLE.

Verification
REQ-032 Reset, start pulse, caixa_presente=1, 12 sensor pulses -> ovos 1..11, then 0; duzias_total=1; ejetar_caixa high 4 cycles; estado=ESPERA_CAIXA.
REQ-033 Run 10 full boxes -> after 10th ejection estado=CHEIO, alarme_cheio=1, duzias_total=10; start edge -> duzias_total=0, estado=ESPERA_CAIXA.
REQ-034 Hold sensor_ovo high 20 cycles in ENCHENDO -> ovos_na_caixa increments by exactly 1.
REQ-035 5 eggs, then stop=1 -> IDLE, ovos_na_caixa=5; start, box -> 7 more eggs completes the box.
REQ-036 12th egg with stop=1 in the same cycle -> EJETANDO for 4 cycles, then IDLE with duzias_total=1.
REQ-037 Eggs with caixa_presente=0 not counted and motor_esteira=0; reset_n low during EJETANDO -> all outputs 0 asynchronously.
